// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// One-bit full adder cell; the only arithmetic element of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  // Classic sum/majority equations for a single bit position
  always_comb begin
    sum   = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one operand pair is accepted, then one
// bit pair per cycle (LSB first) goes through a single full adder while the
// running carry lives in a flop. The result is returned over valid/ready.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cOut_q, cOut_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             lastBit;
  logic             faSum;
  logic             faCout;

  fulladder uFa (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .c_in (carry_q),
    .sum  (faSum),
    .c_out(faCout)
  );

  assign accept  = start_valid & start_ready;
  assign lastBit = (cnt_q == CNT_LAST);

  // State register plus datapath flops; reset clears everything visible
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      aSh_q    <= '0;
      bSh_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cOut_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cOut_q   <= cOut_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: a done result either retires to idle or is replaced
  // immediately by a new operation in the same handshake cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (lastBit) state_d = S_DONE;
      S_DONE: begin
        if (accept) state_d = S_RUN;
        else if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state; the
  // res_ready -> start_ready path lets back-to-back ops skip the idle cycle
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_IDLE: start_ready = !rst;
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        res_valid   = 1'b1;
        start_ready = !rst & res_ready;
      end
      default: ;
    endcase
  end

  // Serial datapath: load on accept (subtract becomes A + ~B + 1 by
  // inverting B and seeding the carry), then shift one bit per RUN cycle
  always_comb begin
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cOut_d   = cOut_q;
    ovf_d    = ovf_q;
    if (accept) begin
      aSh_d   = op_a;
      bSh_d   = sub ? ~op_b : op_b;
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      aSh_d    = aSh_q >> 1;
      bSh_d    = bSh_q >> 1;
      result_d = {faSum, result_q[WIDTH-1:1]};
      carry_d  = faCout;
      if (lastBit) begin
        cOut_d = faCout;
        ovf_d  = carry_q ^ faCout;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign result   = result_q;
  assign c_out    = cOut_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with WIDTH=8; expected values come
// from a plain arithmetic model of add/subtract with signed-range overflow.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sub        (sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .c_out      (c_out),
    .overflow   (overflow),
    .busy       (busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Reference: {overflow, carry-out, result} from integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W:0] full;
    logic [W-1:0] nb;
    int sa, sb, r;
    logic ov;
    sa = $signed(a);
    sb = $signed(b);
    nb = ~b;
    if (s) begin
      full = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
      r    = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r    = sa + sb;
    end
    ov = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    return {ov, full[W], full[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op with start_valid for one edge (caller ensures ready)
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    op_a = a;
    op_b = b;
    sub = s;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  // Bounded wait for res_valid, counting cycles and busy cycles seen
  task automatic wait_result(output int cycles, output int busyCnt);
    cycles = 0;
    busyCnt = 0;
    while (!res_valid && cycles < 40) begin
      if (busy) busyCnt++;
      tick();
      cycles++;
    end
  endtask

  task automatic drain();
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({res_valid, busy, c_out, overflow, result} !== {4'b0000, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got valid=%b busy=%b co=%b ov=%b res=%h expected all zero",
               res_valid, busy, c_out, overflow, result);
    end
    vectors++;
    if (start_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got start_ready=%b expected 0 during rst", start_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (start_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got start_ready=%b expected 1", start_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [W-1:0] tb[5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
    logic         ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] te[5] = '{{2'b00, 8'h10}, {2'b01, 8'h00}, {2'b10, 8'h80},
                            {2'b00, 8'hFE}, {2'b11, 8'h7F}};
    int cyc, bc;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (start_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL directed_ready[%0d]: got %b expected 1", i, start_ready);
      end
      launch(ta[i], tb[i], ts[i]);
      wait_result(cyc, bc);
      vectors++;
      if (cyc !== W || bc !== W) begin
        miscompares++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d cycles busy %0d expected %0d", i, cyc, bc, W);
      end
      vectors++;
      if ({overflow, c_out, result} !== te[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_result[%0d]: got ov=%b co=%b res=%h expected ov=%b co=%b res=%h",
                 i, overflow, c_out, result, te[i][W+1], te[i][W], te[i][W-1:0]);
      end
      drain();
      vectors++;
      if (res_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL directed_retire[%0d]: got res_valid=%b expected 0", i, res_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b;
    logic s;
    logic [W+1:0] exp;
    int cyc, bc;
    a = W'($urandom); b = W'($urandom); s = 1'($urandom);
    exp = model(a, b, s);
    launch(a, b, s);
    wait_result(cyc, bc);
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'($urandom);
      op_a = W'($urandom);
      op_b = W'($urandom);
      sub = 1'($urandom);
      #1;
      vectors++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b0 ||
          {overflow, c_out, result} !== exp) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b ready=%b busy=%b res=%h expected 1/0/0 res=%h",
                 i, res_valid, start_ready, busy, {overflow, c_out, result}, exp);
      end
      tick();
    end
    a = W'($urandom); b = W'($urandom); s = 1'($urandom);
    exp = model(a, b, s);
    op_a = a; op_b = b; sub = s;
    start_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    vectors++;
    if (start_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_release_ready: got start_ready=%b expected 1", start_ready);
    end
    tick();
    start_valid = 1'b0;
    res_ready = 1'b0;
    vectors++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_reaccept: got busy=%b valid=%b expected 1/0", busy, res_valid);
    end
    wait_result(cyc, bc);
    vectors++;
    if (cyc !== W || {overflow, c_out, result} !== exp) begin
      miscompares++;
      $display("[TB] FAIL stall_next_result: got %0d cycles res=%h expected %0d cycles res=%h",
               cyc, {overflow, c_out, result}, W, exp);
    end
    drain();
  endtask

  task automatic test_toggle();
    logic [W-1:0] a, b;
    logic s;
    logic [W+1:0] exp;
    int cyc;
    for (int n = 0; n < 4; n++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      exp = model(a, b, s);
      launch(a, b, s);
      cyc = 0;
      while (!res_valid && cyc < 40) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
        sub = ~sub;
        start_valid = 1'($urandom);
        tick();
        cyc++;
      end
      start_valid = 1'b0;
      vectors++;
      if (cyc !== W || {overflow, c_out, result} !== exp) begin
        miscompares++;
        $display("[TB] FAIL toggle_result[%0d]: got %0d cycles res=%h expected %0d cycles res=%h",
                 n, cyc, {overflow, c_out, result}, W, exp);
      end
      drain();
    end
  endtask

  task automatic test_abort();
    int cyc, bc;
    launch(8'hFF, 8'hFF, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_state: got busy=%b valid=%b expected 0/0", busy, res_valid);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (start_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_ready: got start_ready=%b expected 1", start_ready);
    end
    launch(8'h01, 8'h01, 1'b0);
    wait_result(cyc, bc);
    vectors++;
    if (cyc !== W || {overflow, c_out, result} !== {2'b00, 8'h02}) begin
      miscompares++;
      $display("[TB] FAIL abort_next_op: got %0d cycles res=%h expected %0d cycles res=002",
               cyc, {overflow, c_out, result}, W);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] expQ[$];
    logic [W-1:0] a, b;
    logic s;
    logic [W+1:0] exp;
    int cyc, bc;
    a = W'($urandom); b = W'($urandom); s = 1'($urandom);
    expQ.push_back(model(a, b, s));
    launch(a, b, s);
    for (int i = 0; i < 6; i++) begin
      wait_result(cyc, bc);
      exp = expQ.pop_front();
      vectors++;
      if (cyc !== W || {overflow, c_out, result} !== exp) begin
        miscompares++;
        $display("[TB] FAIL b2b_result[%0d]: got %0d cycles res=%h expected %0d cycles res=%h",
                 i, cyc, {overflow, c_out, result}, W, exp);
      end
      if (i < 5) begin
        a = W'($urandom); b = W'($urandom); s = 1'($urandom);
        expQ.push_back(model(a, b, s));
        op_a = a; op_b = b; sub = s;
        start_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        start_valid = 1'b0;
        res_ready = 1'b0;
      end else begin
        drain();
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic s;
    logic [W+1:0] exp;
    int cyc, bc;
    for (int n = 0; n < 20; n++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      exp = model(a, b, s);
      launch(a, b, s);
      wait_result(cyc, bc);
      vectors++;
      if (cyc !== W || {overflow, c_out, result} !== exp) begin
        miscompares++;
        $display("[TB] FAIL random_result[%0d]: a=%h b=%h sub=%b got %0d cycles res=%h expected %0d cycles res=%h",
                 n, a, b, s, cyc, {overflow, c_out, result}, W, exp);
      end
      for (int d = 0; d < int'($urandom_range(0, 2)); d++) tick();
      drain();
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_toggle();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
